// File: rtl/sr_ff_pattern_driver.sv
// Drives an SR flip-flop through a target bit pattern (MSB first) and counts q/qbar mismatches.
// Optional macro SR_MISMATCH_STOP_EN ends the run at the first mismatching bit.
module sr_ff_pattern_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  output logic                   s,
  output logic                   r,
  input  logic                   q_fb,
  input  logic                   qbar_fb,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       err_count,
  output logic [$clog2(WIDTH):0] bit_idx,
  output logic [1:0]             dbg_state
);

  localparam int IDXW = $clog2(WIDTH) + 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // start is a level sampled only in IDLE (no ready); done is a one-cycle pulse in DONE.
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic             r_s;
  logic             r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;
  logic [IDXW-1:0]  r_bit_idx;

  logic             w_t_cur;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_t_nxt;
  logic             w_last;
  logic             w_mismatch;
  logic             w_stop;

  assign w_t_cur     = r_shift[WIDTH-1];
  assign w_shift_nxt = r_shift << 1;
  assign w_t_nxt     = w_shift_nxt[WIDTH-1];
  assign w_last      = (r_bit_idx == '0);

  // Written as "match clears mismatch" so an unknown feedback counts as a mismatch.
  always_comb begin
    w_mismatch = 1'b1;
    if ((q_fb == w_t_cur) && (qbar_fb == ~q_fb)) w_mismatch = 1'b0;
  end

`ifdef SR_MISMATCH_STOP_EN
  assign w_stop = w_last | w_mismatch;
`else
  assign w_stop = w_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_s         <= 1'b0;
      r_r         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_bit_idx   <= IDX_TOP;
    end else begin
      // Excitation is loaded on entry to DRIVE so the flop sees it for exactly one edge.
      r_s    <= 1'b0;
      r_r    <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift     <= pattern;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_bit_idx   <= IDX_TOP;
            r_s         <= pattern[WIDTH-1] & ~q_fb;
            r_r         <= ~pattern[WIDTH-1] & q_fb;
            r_busy      <= 1'b1;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: r_state <= ST_CHECK;
        ST_CHECK: begin
          if (w_mismatch) begin
            r_err <= 1'b1;
            if (!(&r_err_count)) r_err_count <= r_err_count + 1'b1;
          end
          if (w_stop) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_bit_idx <= r_bit_idx - 1'b1;
            r_shift   <= w_shift_nxt;
            r_s       <= w_t_nxt & ~q_fb;
            r_r       <= ~w_t_nxt & q_fb;
            r_state   <= ST_DRIVE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s         = r_s;
  assign r         = r_r;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign bit_idx   = r_bit_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sr_ff_pattern_driver.sv
// Bench for sr_ff_pattern_driver: a behavioural SR flop with fault injection, a per-bit
// reference model, table vectors, hand-written corner sequences and random runs.
module tb_sr_ff_pattern_driver;
  localparam int W = 8;
  localparam int CW = 6;

  logic clk, rst, start;
  logic [W-1:0] pattern;
  logic s, r, q_fb, qbar_fb, busy, done, err;
  logic [CW-1:0] err_count;
  logic [$clog2(W):0] bit_idx;
  logic [1:0] dbg_state;

  // Feedback fault modes: 0 none, 1 q stuck at 0, 2 qbar==q on bit 3 check, 3 q stuck at 1.
  int   fault_mode;
  logic qbar_bad;
  logic ff_q, ff_load, ff_load_val;

  int n_checks = 0;
  int n_fail = 0;
  int both_hi = 0;

  logic m_s_q[$];
  logic m_r_q[$];
  int   m_bits, m_cnt;

  typedef struct {
    logic [W-1:0] pat;
    logic         q0;
    int           mode;
    logic         exp_err;
    int           exp_cnt;
    int           exp_s;
    int           exp_r;
  } vec_t;
  vec_t vecs[7];

  sr_ff_pattern_driver #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
    .busy(busy), .done(done), .err(err), .err_count(err_count),
    .bit_idx(bit_idx), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ff_load) ff_q <= ff_load_val;
    else if (s && !r) ff_q <= 1'b1;
    else if (r && !s) ff_q <= 1'b0;
  end

  assign q_fb    = (fault_mode == 1) ? 1'b0 : (fault_mode == 3) ? 1'b1 : ff_q;
  assign qbar_fb = qbar_bad ? q_fb : ~q_fb;

  always @(negedge clk) if (s && r) both_hi++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fb_of(input logic q, input int mode);
    return (mode == 1) ? 1'b0 : (mode == 3) ? 1'b1 : q;
  endfunction

  // Walk the bits as the flop sees them: excite toward the target, then judge the result.
  task automatic model_run(input logic [W-1:0] pat, input logic q0, input int mode);
    logic q, t, fb, sv, rv, qa, qba;
    m_s_q.delete(); m_r_q.delete();
    m_bits = 0; m_cnt = 0; q = q0;
    for (int b = W - 1; b >= 0; b--) begin
      t  = pat[b];
      fb = fb_of(q, mode);
      sv = t && !fb;
      rv = !t && fb;
      m_s_q.push_back(sv);
      m_r_q.push_back(rv);
      if (sv) q = 1'b1;
      else if (rv) q = 1'b0;
      m_bits++;
      qa  = fb_of(q, mode);
      qba = (mode == 2 && b == 3) ? qa : !qa;
      if (qa != t || qba != !qa) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
`ifdef SR_MISMATCH_STOP_EN
        break;
`endif
      end
    end
  endtask

  task automatic run_vector(input string nm, input logic [W-1:0] pat, input logic q0,
                            input int mode, input bit use_exp, input vec_t v,
                            input int abort_at, input bit poke);
    int run_len, k, s_cnt, r_cnt;
    logic exp_err;
    int exp_cnt;
    model_run(pat, q0, mode);
    exp_err = use_exp ? v.exp_err : (m_cnt != 0);
    exp_cnt = use_exp ? v.exp_cnt : m_cnt;
    run_len = 2 * m_bits + 1;
    s_cnt = 0; r_cnt = 0;
    @(negedge clk);
    fault_mode = mode; ff_load = 1'b1; ff_load_val = q0; start = 1'b0; qbar_bad = 1'b0;
    @(negedge clk);
    ff_load = 1'b0; pattern = pat; start = 1'b1;
    for (int i = 1; i <= run_len + 1; i++) begin
      @(negedge clk);
      start = 1'b0; qbar_bad = 1'b0; pattern = W'($urandom);
      if (s) s_cnt++;
      if (r) r_cnt++;
      if (abort_at != 0 && i == abort_at + 1) begin
        rst = 1'b0;
        check({nm, "_rst_busy"}, busy, 0);
        check({nm, "_rst_s"}, s, 0);
        check({nm, "_rst_r"}, r, 0);
        check({nm, "_rst_cnt"}, err_count, 0);
        check({nm, "_rst_err"}, err, 0);
        check({nm, "_rst_idx"}, bit_idx, W - 1);
        check({nm, "_rst_done"}, done, 0);
        for (int j = 0; j < 2 * W; j++) begin
          @(negedge clk);
          check({nm, "_no_done"}, done, 0);
        end
        return;
      end
      k = (i - 1) / 2;
      if (i <= 2 * m_bits) begin
        check({nm, "_busy"}, busy, 1);
        check({nm, "_done_lo"}, done, 0);
        check({nm, "_idx"}, bit_idx, W - 1 - k);
        if (i % 2 == 1) begin
          check({nm, "_s"}, s, m_s_q[k]);
          check({nm, "_r"}, r, m_r_q[k]);
        end else begin
          check({nm, "_chk_sr"}, {s, r}, 0);
          if (mode == 2 && W - 1 - k == 3) qbar_bad = 1'b1;
        end
        if (poke && i == 5) begin start = 1'b1; pattern = ~pat; end
        if (i == abort_at) rst = 1'b1;
      end else if (i == run_len) begin
        check({nm, "_done"}, done, 1);
        check({nm, "_done_busy"}, busy, 1);
        check({nm, "_done_sr"}, {s, r}, 0);
        check({nm, "_done_idx"}, bit_idx, W - m_bits);
        check({nm, "_err"}, err, exp_err);
        check({nm, "_cnt"}, err_count, exp_cnt);
        if (poke) begin start = 1'b1; pattern = ~pat; end
      end else begin
        check({nm, "_after_done"}, done, 0);
        check({nm, "_after_busy"}, busy, 0);
        if (poke) begin start = 1'b1; pattern = 8'hFF; end
      end
    end
    if (use_exp) begin
      check({nm, "_s_pulses"}, s_cnt, v.exp_s);
      check({nm, "_r_pulses"}, r_cnt, v.exp_r);
    end
  endtask

  initial begin
    vec_t dummy;
    dummy = '{pat: '0, q0: 1'b0, mode: 0, exp_err: 1'b0, exp_cnt: 0, exp_s: 0, exp_r: 0};
    vecs[0] = '{8'hA6, 1'b0, 0, 1'b0, 0, 3, 3};
    vecs[1] = '{8'hFF, 1'b0, 0, 1'b0, 0, 1, 0};
`ifdef SR_MISMATCH_STOP_EN
    vecs[2] = '{8'hF0, 1'b0, 1, 1'b1, 1, 1, 0};
    vecs[5] = '{8'h0F, 1'b1, 3, 1'b1, 1, 0, 1};
`else
    vecs[2] = '{8'hF0, 1'b0, 1, 1'b1, 4, 4, 0};
    vecs[5] = '{8'h0F, 1'b1, 3, 1'b1, 4, 0, 4};
`endif
    vecs[3] = '{8'h00, 1'b0, 2, 1'b1, 1, 0, 0};
    vecs[4] = '{8'h00, 1'b1, 0, 1'b0, 0, 0, 1};
    vecs[6] = '{8'h55, 1'b1, 0, 1'b0, 0, 4, 4};

    rst = 1'b1; start = 1'b0; pattern = '0; fault_mode = 0; qbar_bad = 1'b0;
    ff_load = 1'b1; ff_load_val = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_s", s, 0);
    check("reset_r", r, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_cnt", err_count, 0);
    check("reset_idx", bit_idx, W - 1);
    rst = 1'b0; ff_load = 1'b0;

    foreach (vecs[n]) run_vector($sformatf("vec%0d", n), vecs[n].pat, vecs[n].q0,
                                 vecs[n].mode, 1'b1, vecs[n], 0, 1'b0);

    // Start pulses mid-run and in DONE are ignored; the one in the next IDLE cycle is taken.
    run_vector("poke", vecs[0].pat, 1'b0, 0, 1'b1, vecs[0], 0, 1'b1);
    for (int j = 1; j <= 2 * W + 2; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 1) check("late_start_busy", busy, 1);
      if (j == 1) check("late_start_cnt", err_count, 0);
      check("late_start_done", done, (j == 2 * W + 1) ? 1 : 0);
    end
    check("late_start_err", err, 0);

`ifdef SR_MISMATCH_STOP_EN
    run_vector("abort", 8'hF0, 1'b0, 0, 1'b0, dummy, 8, 1'b0);
`else
    run_vector("abort", 8'hF0, 1'b0, 1, 1'b0, dummy, 8, 1'b0);
`endif
    run_vector("post_abort", vecs[0].pat, 1'b0, 0, 1'b1, vecs[0], 0, 1'b0);

    for (int n = 0; n < 20; n++)
      run_vector($sformatf("rand%0d", n), W'($urandom), 1'(($urandom_range(0, 1))),
                 int'($urandom_range(0, 3)), 1'b0, dummy, 0, 1'b0);

    check("never_s_and_r", both_hi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
